// File: rtl/seq_alu.sv
// seq_alu: sequential 16-bit ALU with a single-cycle EXEC path and a
// 16-iteration shift-add multiplier. Results, flags and the done pulse
// are all registered; operands and opcode are captured at issue.
module seq_alu (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic [15:0] C,
    output logic        busy,
    output logic        done,
    output logic        zero,
    output logic        carry
);

    // FSM encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;

    // Opcode encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [4:0] LAST_ITER = 5'd15;

    logic [1:0]  state;
    logic [15:0] aReg;
    logic [15:0] bReg;
    logic [2:0]  opReg;
    logic [4:0]  iterCnt;

    // Multiplier datapath: accumulator, left-shifting multiplicand,
    // right-shifting multiplier (LSB is the bit consumed this cycle)
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] accNext;
    logic        mulLast;

    logic        accept;
    logic [15:0] aluRes;
    logic        aluCarry;

    logic [16:0] sum17;
    logic [16:0] diff17;
    logic [31:0] shl32;
    logic [31:0] shr32;

    assign accept  = (state == IDLE) && start;
    assign mulLast = (iterCnt == LAST_ITER);

    // Single-cycle ALU on the latched operands; shift carries fall out of
    // the widened shift (the bit just beyond the result), which is
    // naturally 0 for a shift amount of 0.
    always_comb begin
        sum17    = {1'b0, aReg} + {1'b0, bReg};
        diff17   = {1'b0, aReg} - {1'b0, bReg};
        shl32    = {16'h0000, aReg} << bReg[3:0];
        shr32    = {aReg, 16'h0000} >> bReg[3:0];
        aluRes   = '0;
        aluCarry = 1'b0;
        case (opReg)
            OP_ADD: begin
                aluRes   = sum17[15:0];
                aluCarry = sum17[16];
            end
            OP_SUB: begin
                aluRes   = diff17[15:0];
                aluCarry = diff17[16];
            end
            OP_AND: aluRes = aReg & bReg;
            OP_OR:  aluRes = aReg | bReg;
            OP_XOR: aluRes = aReg ^ bReg;
            OP_SHL: begin
                aluRes   = shl32[15:0];
                aluCarry = shl32[16];
            end
            OP_SHR: begin
                aluRes   = shr32[31:16];
                aluCarry = shr32[15];
            end
            default: begin
                aluRes   = '0;
                aluCarry = 1'b0;
            end
        endcase
    end

    // Next accumulator value for the current multiplier bit
    always_comb begin
        accNext = acc;
        if (mplier[0]) begin
            accNext = acc + mcand;
        end
    end

    // Control FSM: issue, single-cycle execute, 16-step multiply
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            busy    <= 1'b0;
            iterCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        iterCnt <= '0;
                        state   <= (op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                MUL: begin
                    iterCnt <= iterCnt + 5'd1;
                    if (mulLast) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand/opcode capture; only an accepted start may update them
    always_ff @(posedge clk) begin
        if (clear) begin
            aReg  <= '0;
            bReg  <= '0;
            opReg <= '0;
        end else if (accept) begin
            aReg  <= A;
            bReg  <= B;
            opReg <= op;
        end
    end

    // Shift-add multiplier datapath, loaded directly from the ports at issue
    always_ff @(posedge clk) begin
        if (clear) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {16'h0000, A};
            mplier <= B;
        end else if (state == MUL) begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Result and flag registers, updated only on completion; done pulses
    always_ff @(posedge clk) begin
        if (clear) begin
            C     <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == EXEC) begin
                C     <= aluRes;
                carry <= aluCarry;
                zero  <= (aluRes == 16'h0000);
                done  <= 1'b1;
            end else if ((state == MUL) && mulLast) begin
                C     <= accNext[15:0];
                carry <= (accNext[31:16] != 16'h0000);
                zero  <= (accNext[15:0] == 16'h0000);
                done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven, hand-sequenced and randomized checks of seq_alu
// against an arithmetic reference model.
module tb_seq_alu;

    logic        clk;
    logic        clear;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  op;
    logic        start;
    logic [15:0] C;
    logic        busy;
    logic        done;
    logic        zero;
    logic        carry;

    int nChecks = 0;
    int nFails  = 0;

    seq_alu dut (
        .clk   (clk),
        .clear (clear),
        .A     (A),
        .B     (B),
        .op    (op),
        .start (start),
        .C     (C),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expC;
        logic        expCarry;
        logic        expZero;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain integer arithmetic on the operands
    task automatic refModel(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] c, output logic cy);
        int unsigned ua;
        int unsigned ub;
        int unsigned s;
        int unsigned r;
        ua = a;
        ub = b;
        s  = ub % 16;
        r  = 0;
        cy = 1'b0;
        case (o)
            3'd0: begin r = ua + ub;  cy = (r >= 65536); end
            3'd1: begin r = (ua + 65536 - ub); cy = (ua < ub); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua * (1 << s); cy = (s != 0) && (((ua >> (16 - s)) & 1) == 1); end
            3'd6: begin r = ua / (1 << s); cy = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            default: begin r = ua * ub; cy = (r / 65536) != 0; end
        endcase
        c = 16'(r % 65536);
    endtask

    // Issue one op at the next edge; called #1 after a rising edge.
    // Returns the number of edges from the issue edge to done.
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic got);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        chk("busy_after_issue", 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input string name, input logic [2:0] o, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] expC,
                               input logic expCarry, input logic expZero);
        int   lat;
        logic got;
        issue(o, a, b, lat, got);
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"}, 32'(lat), (o == 3'd7) ? 32'd16 : 32'd1);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({name, "_C"}, 32'(C), 32'(expC));
        chk({name, "_carry"}, 32'(carry), 32'(expCarry));
        chk({name, "_zero"}, 32'(zero), 32'(expZero));
        @(posedge clk); #1;
        chk({name, "_done_single"}, 32'(done), 32'd0);
        chk({name, "_C_hold"}, 32'(C), 32'(expC));
    endtask

    initial begin
        int          lat;
        logic        got;
        int          nDone;
        logic [15:0] rc;
        logic        rcy;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rop;
        logic [15:0] edgeVals[6];

        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
        vecs[2]  = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0};
        vecs[3]  = '{3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{3'd7, 16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0};
        vecs[5]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
        vecs[6]  = '{3'd3, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0};
        vecs[7]  = '{3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
        vecs[8]  = '{3'd6, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0};
        vecs[9]  = '{3'd5, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
        vecs[10] = '{3'd6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0};
        vecs[12] = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
        vecs[13] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};
        vecs[14] = '{3'd7, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0};

        edgeVals = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h000F};

        clear = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        A     = 16'h1111;
        B     = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_C", 32'(C), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_zero", 32'(zero), 32'd0);
        chk("reset_carry", 32'(carry), 32'd0);
        clear = 1'b0;

        // Table vectors; the first is issued at the first edge with clear low
        for (int i = 0; i < 15; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                        vecs[i].expC, vecs[i].expCarry, vecs[i].expZero);
        end

        // start during MUL is ignored
        start = 1'b1; op = 3'd7; A = 16'h0007; B = 16'h0009;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                start = 1'b1; op = 3'd0; A = 16'h1000; B = 16'h0234;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        chk("mulign_done_seen", 32'(got), 32'd1);
        chk("mulign_latency", 32'(lat), 32'd16);
        chk("mulign_C", 32'(C), 32'h003F);
        chk("mulign_carry", 32'(carry), 32'd0);
        nDone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) nDone++;
            if (busy) nDone++;
        end
        chk("mulign_no_extra_activity", 32'(nDone), 32'd0);

        // Back-to-back issue in the done cycle
        issue(3'd2, 16'hF0F0, 16'h0FF0, lat, got);
        chk("b2b_first_done", 32'(got), 32'd1);
        chk("b2b_first_C", 32'(C), 32'h00F0);
        start = 1'b1; op = 3'd0; A = 16'h1234; B = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_gap_done", 32'(done), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        chk("b2b_gap_C_hold", 32'(C), 32'h00F0);
        @(posedge clk); #1;
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_C", 32'(C), 32'h2345);
        @(posedge clk); #1;

        // clear aborts a MUL mid-flight
        runAndCheck("pre_abort", 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0);
        start = 1'b1; op = 3'd7; A = 16'h00FF; B = 16'h0003;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_C", 32'(C), 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_carry", 32'(carry), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        nDone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) nDone++;
        end
        chk("abort_no_done", 32'(nDone), 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : 16'($urandom);
            refModel(rop, ra, rb, rc, rcy);
            runAndCheck($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rc, rcy, (rc == 16'h0000));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            chk($sformatf("rnd%0d_C_idle_hold", i), 32'(C), 32'(rc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
